// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions.
//   - funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - load_store_unit FSM state type
//   - access_fault(): flags an illegal funct3 or a misaligned address
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } lsu_state_e;

    // Stores share the load encodings for B/H/W, so one table covers both.
    function automatic logic access_fault(input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic fault;
        case (funct3)
            F3_LB, F3_LBU: fault = 1'b0;
            F3_LH, F3_LHU: fault = offset[0];
            F3_LW:         fault = |offset;
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   funct3    in  3  - access size / signedness
//   offset    in  2  - byte offset within the word (addr[1:0])
//   wdata     in  32 - right-aligned store data
//   rdata     in  32 - raw memory word
//   be        out 4  - byte enables for the addressed lanes
//   wdata_rep out 32 - store data replicated across all lanes
//   rdata_ext out 32 - addressed lane, sign- or zero-extended
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            F3_SB[1:0]: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_SH[1:0]: begin
                be        = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        lane      = rdata >> {offset, 3'b000};
        rdata_ext = lane;
        case (funct3)
            F3_LB:   rdata_ext = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  rdata_ext = {24'd0, lane[7:0]};
            F3_LH:   rdata_ext = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  rdata_ext = {16'd0, lane[15:0]};
            default: rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: one load or store per transaction from execute,
// driven onto a request/grant/rvalid memory port.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_valid/req_ready  - execute-stage handshake (ready only when idle)
//   req_we/addr/wdata/funct3 - access description, captured on accept
//   mem_req/we/addr/be/wdata - memory request, held stable while in REQ
//   mem_gnt/rvalid/rdata - memory acceptance and read return
//   rsp_valid/rsp_err    - one-cycle completion pulse and error flag
//   RD                   - extended load data, held until the next good load
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [XLEN-1:0] RD
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT);

    lsu_state_e      state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd_q;
    logic            err_q;
    logic [7:0]      cnt_q;

    logic            req_fault;
    logic            hit_limit;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rdata_ext;

    assign req_fault = access_fault(req_funct3, req_addr[1:0]);
    // Fires on the cycle whose increment would make the count reach TIMEOUT,
    // so mem_req stays high for exactly TIMEOUT cycles without a grant.
    assign hit_limit = ({1'b0, cnt_q} + 9'd1) == LIMIT;

    lsu_align u_align (
        .funct3    (funct3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = req_fault ? RESP : REQ;
            end
            REQ: begin
                // A grant wins over a simultaneous rvalid or timeout.
                if (mem_gnt)        state_d = we_q ? RESP : WAIT_R;
                else if (hit_limit) state_d = RESP;
            end
            WAIT_R: begin
                if (mem_rvalid || hit_limit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= req_fault;
                        cnt_q    <= '0;
                    end
                end
                REQ: begin
                    if (mem_gnt)        cnt_q <= '0;
                    else if (hit_limit) err_q <= 1'b1;
                    else                cnt_q <= cnt_q + 8'd1;
                end
                WAIT_R: begin
                    if (mem_rvalid)     rd_q  <= rdata_ext;
                    else if (hit_limit) err_q <= 1'b1;
                    else                cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be    = mem_req ? be : '0;
    assign mem_wdata = (mem_req & we_q) ? wdata_rep : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign RD        = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory
// requests and responses; a monitor pops and compares them; a randomized
// memory responder supplies grants and read data.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] RD;

    load_store_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .RD         (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic err; logic [31:0] rd; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } mreq_t;

    rsp_t        rsp_q[$];
    mreq_t       mreq_q[$];
    int          n_cmp;
    int          n_fail;
    logic [31:0] rd_model;
    bit          manual, no_grant, fast;
    logic [31:0] mem_img [logic [31:0]];
    logic [2:0]  legal_f3 [5];
    logic [2:0]  illegal_f3 [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] waddr);
        if (mem_img.exists(waddr)) return mem_img[waddr];
        return (waddr * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic int unsigned nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_err(input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    // Reference load result: shift the word down by the byte offset, keep the
    // access width, extend from the top kept bit for signed forms.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        logic [63:0] w, mask;
        n    = nbytes(f3);
        w    = {32'd0, word_of(a & ~32'd3)} >> (8 * (a % 4));
        mask = (64'd1 << (8 * n)) - 64'd1;
        w    = w & mask;
        if (!f3[2] && n < 4 && w[8*n-1]) w = w | ~mask;
        return w[31:0];
    endfunction

    function automatic logic [31:0] store_val(input logic [2:0] f3, input logic [31:0] d);
        int unsigned n;
        n = nbytes(f3);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int nreq);
        rsp_t  r;
        mreq_t m;
        bit    e;
        int    guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("ready_wait", 32'(req_ready), 32'd1);
        e = is_err(f3, a);
        if (!e && !no_grant) begin
            m.we    = we;
            m.addr  = a & ~32'd3;
            m.be    = 4'(((32'd1 << nbytes(f3)) - 32'd1) << (a % 4));
            m.wdata = store_val(f3, d);
            mreq_q.push_back(m);
            if (!we) rd_model = load_val(f3, a);
        end
        r.err = e || no_grant;
        r.rd  = rd_model;
        rsp_q.push_back(r);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat  = 0;
        nreq = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_req) nreq++;
        end while (!rsp_valid && lat < 60);
        if (!rsp_valid) chk("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    // Memory responder: grant/rvalid driven at negedge from the observed request.
    initial begin
        int          gw, rw;
        bit          pend;
        logic [31:0] pa;
        gw = 0; rw = 0; pend = 0; pa = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!manual) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                if (pend) begin
                    if (rw == 0 || fast) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = word_of(pa);
                        pend       = 0;
                    end else rw--;
                end
                if (mem_req && !no_grant) begin
                    if (gw == 0 || fast) begin
                        mem_gnt = 1'b1;
                        gw      = $urandom_range(0, 2);
                        if (!mem_we) begin
                            pend = 1;
                            pa   = mem_addr;
                            rw   = $urandom_range(0, 2);
                        end
                    end else gw--;
                end
            end
        end
    end

    // Monitor: compares granted requests and completions against the queues.
    initial begin
        mreq_t m;
        rsp_t  r;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && mem_req && mem_gnt) begin
                if (mreq_q.size() == 0) chk("unexpected_gnt_req", 32'(mem_req), 32'd0);
                else begin
                    m = mreq_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_be", 32'(mem_be), 32'(m.be));
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (rst_n && rsp_valid) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rd", RD, r.rd);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, nreq, cnt;
        n_cmp = 0; n_fail = 0; rd_model = '0;
        manual = 0; no_grant = 0; fast = 0;
        legal_f3   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        illegal_f3 = '{3'd3, 3'd6, 3'd7};
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_be", 32'(mem_be), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rd", RD, 32'd0);
        rst_n = 1'b1;

        fast = 1;
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, nreq);
        chk("sw_latency", 32'(lat), 32'd2);
        issue(1'b1, 3'b000, 32'h103, 32'h000000A5, lat, nreq);
        chk("sb_latency", 32'(lat), 32'd2);
        mem_img[32'h100] = 32'h00008000;
        issue(1'b0, 3'b000, 32'h101, 32'h0, lat, nreq);
        chk("lb_latency", 32'(lat), 32'd3);
        chk("lb_rd", RD, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h101, 32'h0, lat, nreq);
        chk("lbu_rd", RD, 32'h00000080);
        mem_img[32'h100] = 32'hBEEF0000;
        issue(1'b0, 3'b101, 32'h102, 32'h0, lat, nreq);
        chk("lhu_rd", RD, 32'h0000BEEF);
        issue(1'b0, 3'b010, 32'h102, 32'h0, lat, nreq);
        chk("misaligned_latency", 32'(lat), 32'd1);
        chk("misaligned_no_req", 32'(nreq), 32'd0);
        chk("misaligned_rd_held", RD, 32'h0000BEEF);

        no_grant = 1;
        issue(1'b0, 3'b010, 32'h200, 32'h0, lat, nreq);
        chk("timeout_req_cycles", 32'(nreq), 32'(TO));
        chk("timeout_rd_held", RD, 32'h0000BEEF);
        no_grant = 0;
        issue(1'b1, 3'b010, 32'h204, 32'h12345678, lat, nreq);
        chk("after_timeout_sw_latency", 32'(lat), 32'd2);

        fast = 0;
        for (int i = 0; i < 250; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            int unsigned k;
            we = 1'($urandom_range(0, 1));
            k  = $urandom_range(0, 19);
            f3 = (k < 18) ? legal_f3[k % 5] : illegal_f3[k % 3];
            a  = 32'h1000 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (nbytes(f3) == 2) a[0] = 1'b0;
                if (nbytes(f3) == 4) a[1:0] = 2'b00;
            end
            issue(we, f3, a, $urandom, lat, nreq);
        end

        // Reset while waiting for read data.
        manual = 1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        begin
            mreq_t m;
            m.we = 1'b0; m.addr = 32'h2000; m.be = 4'b1111; m.wdata = '0;
            mreq_q.push_back(m);
        end
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("manual_req_high", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_r_no_req", 32'(mem_req), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_rd", RD, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        rd_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("late_rvalid_no_rsp", 32'(cnt), 32'd0);
        chk("late_rvalid_rd", RD, 32'd0);
        manual = 0;
        fast   = 1;
        issue(1'b1, 3'b001, 32'h302, 32'h0000CAFE, lat, nreq);
        chk("post_reset_sh_latency", 32'(lat), 32'd2);

        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("mreq_queue_drained", 32'(mreq_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
